// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: PC, ROM addressing, instruction register with
// a valid/ready handshake toward decode, branch redirect and self-jump halt.
module ifetch_ctrl #(
  parameter int                     ROM_WIDTH = 21,
  parameter logic [15:0]            RESET_PC  = 16'h0000,
  parameter logic [ROM_WIDTH-17:0]  JMP_OPC   = 5'b01001
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  output logic [15:0]          rom_addr,
  input  logic [ROM_WIDTH-1:0] rom_data,
  output logic [ROM_WIDTH-1:0] ir,
  output logic [15:0]          ir_pc,
  output logic                 ir_valid,
  input  logic                 ir_ready,
  input  logic                 br_valid,
  input  logic [15:0]          br_target,
  output logic                 halted,
  output logic [1:0]           dbg_state
);

  // Handshake: ir is transferred on any edge where ir_valid=1 and
  // ir_ready=1; ir, ir_pc stay stable while ir_valid=1 and ir_ready=0.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [15:0]          pc, pc_n;
  logic [ROM_WIDTH-1:0] ir_n;
  logic [15:0]          ir_pc_n;
  logic                 ir_valid_n;
  logic                 load;
  logic                 self_jump;

  assign rom_addr  = pc;
  assign dbg_state = state;

  assign self_jump = (rom_data[ROM_WIDTH-1:16] == JMP_OPC) && (rom_data[15:0] == pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      ir       <= ir_n;
      ir_pc    <= ir_pc_n;
      ir_valid <= ir_valid_n;
      halted   <= (state_n == HALT);
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ir_n       = ir;
    ir_pc_n    = ir_pc;
    ir_valid_n = ir_valid;
    load       = 1'b0;
    if (!run) begin
      state_n    = IDLE;
      ir_valid_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (br_valid) pc_n = br_target;
          state_n = FETCH;
        end
        FETCH: begin
          if (br_valid) begin
            // Flush: the pending instruction is dropped even if consumed now.
            pc_n       = br_target;
            ir_valid_n = 1'b0;
          end else if (!ir_valid || ir_ready) begin
            load = 1'b1;
          end
        end
        HALT: begin
          ir_valid_n = ir_valid & ~ir_ready;
        end
        default: begin
          state_n    = IDLE;
          ir_valid_n = 1'b0;
        end
      endcase
    end
    if (load) begin
      ir_n       = rom_data;
      ir_pc_n    = pc;
      ir_valid_n = 1'b1;
      if (self_jump) begin
        pc_n    = rom_data[15:0];
        state_n = HALT;
      end else begin
        pc_n = pc + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: ROM model, expected-load scoreboard queue,
// immediate-assertion checks after each clock edge.
module tb_ifetch_ctrl;

  localparam int W = 21;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic         clk;
  logic         rst_n;
  logic         run;
  logic [15:0]  rom_addr;
  logic [W-1:0] rom_data;
  logic [W-1:0] ir;
  logic [15:0]  ir_pc;
  logic         ir_valid;
  logic         ir_ready;
  logic         br_valid;
  logic [15:0]  br_target;
  logic         halted;
  logic [1:0]   dbg_state;

  logic [W-1:0]    rom_mem [0:65535];
  logic [W+15:0]   exp_q[$];
  int              total;
  int              bad;

  ifetch_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .br_valid  (br_valid),
    .br_target (br_target),
    .halted    (halted),
    .dbg_state (dbg_state)
  );

  assign rom_data = rom_mem[rom_addr];

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W+15:0] obs, input logic [W+15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_load(input logic [15:0] addr);
    exp_q.push_back({rom_mem[addr], addr});
  endtask

  // Pops the next expected load and compares it with the current ir/ir_pc.
  task automatic check_load(input string tag);
    logic [W+15:0] exp;
    check({tag, "_valid"}, {36'd0, ir_valid}, {36'd0, 1'b1});
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: got load ir_pc=%0h want no pending load", tag, ir_pc);
    end else begin
      exp = exp_q.pop_front();
      check(tag, {ir, ir_pc}, exp);
    end
  endtask

  task automatic check_idle_outs(input string tag, input logic [15:0] addr);
    check({tag, "_addr"}, {21'd0, rom_addr}, {21'd0, addr});
    check({tag, "_valid"}, {36'd0, ir_valid}, {36'd0, 1'b0});
    check({tag, "_halted"}, {36'd0, halted}, {36'd0, 1'b0});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 65536; i++) rom_mem[i] = {5'b00011, i[15:0] ^ 16'h5a5a};
    rom_mem[0]  = 21'b111010000000000000101;
    rom_mem[1]  = 21'b111010000000000000011;
    rom_mem[16] = 21'b010010000000000010000;

    rst_n = 1'b0; run = 1'b0; ir_ready = 1'b0; br_valid = 1'b0; br_target = 16'h0;
    #23;
    check_idle_outs("rst", 16'h0000);
    check("rst_ir", {ir, ir_pc}, '0);
    check("rst_state", {35'd0, dbg_state}, {35'd0, S_IDLE});
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle_outs("idle_run0", 16'h0000);
    end

    // Streaming
    run = 1'b1; ir_ready = 1'b1;
    for (int a = 0; a < 3; a++) push_load(a[15:0]);
    step();
    check("first_edge_valid", {36'd0, ir_valid}, {36'd0, 1'b0});
    check("first_edge_state", {35'd0, dbg_state}, {35'd0, S_FETCH});
    step(); check_load("stream0");
    step(); check_load("stream1");
    step(); check_load("stream2");

    // Back-pressure while ir_pc=2
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold", {ir, ir_pc}, {rom_mem[2], 16'd2});
      check("bp_valid", {36'd0, ir_valid}, {36'd0, 1'b1});
      check("bp_addr", {21'd0, rom_addr}, {21'd0, 16'd3});
    end
    ir_ready = 1'b1;
    push_load(16'd3); push_load(16'd4);
    step(); check_load("bp_resume3");
    step(); check_load("bp_resume4");

    // Branch while ir_pc=4 and ir_ready=1
    br_valid = 1'b1; br_target = 16'h0008;
    step();
    check("br_bubble", {36'd0, ir_valid}, {36'd0, 1'b0});
    check("br_addr", {21'd0, rom_addr}, {21'd0, 16'h0008});
    br_valid = 1'b0;
    push_load(16'd8); push_load(16'd9);
    step(); check_load("br_tgt8");
    step(); check_load("br_tgt9");

    // Park, then branch from IDLE
    run = 1'b0;
    step();
    check_idle_outs("park", 16'd10);
    check("park_state", {35'd0, dbg_state}, {35'd0, S_IDLE});
    run = 1'b1; br_valid = 1'b1; br_target = 16'h0005;
    step();
    check("idle_br_addr", {21'd0, rom_addr}, {21'd0, 16'h0005});
    check("idle_br_valid", {36'd0, ir_valid}, {36'd0, 1'b0});
    br_valid = 1'b0;
    push_load(16'd5);
    step(); check_load("idle_br5");

    // Halt on self-jump at 16
    br_valid = 1'b1; br_target = 16'd16;
    step();
    check("halt_bubble", {36'd0, ir_valid}, {36'd0, 1'b0});
    br_valid = 1'b0;
    push_load(16'd16);
    step(); check_load("halt_load");
    check("halt_flag", {36'd0, halted}, {36'd0, 1'b1});
    check("halt_addr", {21'd0, rom_addr}, {21'd0, 16'd16});
    check("halt_state", {35'd0, dbg_state}, {35'd0, S_HALT});
    ir_ready = 1'b0; br_valid = 1'b1; br_target = 16'h0020;
    step();
    check("halt_br_ign_addr", {21'd0, rom_addr}, {21'd0, 16'd16});
    check("halt_hold", {ir, ir_pc}, {rom_mem[16], 16'd16});
    check("halt_hold_valid", {36'd0, ir_valid}, {36'd0, 1'b1});
    br_valid = 1'b0;
    ir_ready = 1'b1;
    step();
    check("halt_consumed", {36'd0, ir_valid}, {36'd0, 1'b0});
    check("halt_still", {36'd0, halted}, {36'd0, 1'b1});
    check("halt_noload_pc", {21'd0, ir_pc}, {21'd0, 16'd16});
    run = 1'b0;
    step();
    check_idle_outs("halt_exit", 16'd16);
    run = 1'b1;
    step();
    check("rehalt_fetch_state", {35'd0, dbg_state}, {35'd0, S_FETCH});
    push_load(16'd16);
    step(); check_load("rehalt_load");
    check("rehalt_flag", {36'd0, halted}, {36'd0, 1'b1});

    // Wrap at 16'hFFFF
    run = 1'b0;
    step();
    run = 1'b1; br_valid = 1'b1; br_target = 16'hffff;
    step();
    br_valid = 1'b0;
    push_load(16'hffff); push_load(16'h0000);
    step(); check_load("wrap_ffff");
    check("wrap_addr", {21'd0, rom_addr}, {21'd0, 16'h0000});
    step(); check_load("wrap_0000");
    check("wrap_addr1", {21'd0, rom_addr}, {21'd0, 16'h0001});

    // Asynchronous reset mid-stream, away from any edge
    #2 rst_n = 1'b0;
    #1;
    check_idle_outs("async_rst", 16'h0000);
    check("async_rst_ir", {ir, ir_pc}, '0);
    check("async_rst_state", {35'd0, dbg_state}, {35'd0, S_IDLE});
    check("sb_empty", {5'd0, exp_q.size()}, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
